// File: rtl/sdram_tester_if.sv
// Client-side bus between the memory test sequencer and the SDRAM controller.
// The master drives requests; the slave acknowledges them and returns read data.
interface sdram_tester_if #(
    parameter int unsigned ADDR_WIDTH = 22
);
    logic                  req;
    logic                  ack;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rh_wl;
    logic [15:0]           data_w;
    logic [15:0]           data_r;
    logic                  data_r_en;

    modport master (
        output req, addr, rh_wl, data_w,
        input  ack, data_r, data_r_en
    );

    modport slave (
        input  req, addr, rh_wl, data_w,
        output ack, data_r, data_r_en
    );
endinterface

// File: rtl/sdram_tester.sv
// Built-in SDRAM test sequencer: writes an address/pass-derived pattern over 0..LAST_ADDR,
// reads it back, counts mismatches and captures the first failing location.
module sdram_tester #(
    parameter int unsigned           ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(22'h3FFFFF),
    parameter int unsigned           TIMEOUT    = 16383
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  start,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           pass_cnt,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [15:0]           first_err_exp,
    output logic [15:0]           first_err_act,
    sdram_tester_if.master        sdram
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrReq  = 3'd1;
    localparam logic [2:0] StWrGap  = 3'd2;
    localparam logic [2:0] StRdReq  = 3'd3;
    localparam logic [2:0] StRdWait = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic                  rh_wl_q, rh_wl_d;
    logic [15:0]           data_w_q, data_w_d;
    logic [WdW-1:0]        wdog_q, wdog_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           pass_q, pass_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
    logic [15:0]           fe_exp_q, fe_exp_d;
    logic [15:0]           fe_act_q, fe_act_d;
    logic [15:0]           exp_rd;
    logic                  wdog_hit;

    function automatic logic [15:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] p);
        logic [31:0] w;
        w = 32'(a);
        return w[15:0] ^ w[31:16] ^ {p, p};
    endfunction

    assign exp_rd   = pat(addr_q, pass_q[7:0]);
    assign wdog_hit = (wdog_q == WdW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_d     = req_q;
        rh_wl_d   = rh_wl_q;
        data_w_d  = data_w_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_act_d  = fe_act_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StWrReq;
                    addr_d    = '0;
                    req_d     = 1'b1;
                    rh_wl_d   = 1'b0;
                    data_w_d  = pat('0, 8'h00);
                    timeout_d = 1'b0;
                    pass_d    = '0;
                    err_d     = '0;
                    fe_addr_d = '0;
                    fe_exp_d  = '0;
                    fe_act_d  = '0;
                end
            end
            StWrReq: begin
                // ack takes priority over a coincident watchdog expiry
                if (sdram.ack) begin
                    state_d = StWrGap;
                    req_d   = 1'b0;
                end else if (wdog_hit) begin
                    timeout_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = StDone;
                end
            end
            StWrGap: begin
                req_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    rh_wl_d = 1'b1;
                    state_d = StRdReq;
                end else begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    rh_wl_d  = 1'b0;
                    data_w_d = pat(addr_q + ADDR_WIDTH'(1), pass_q[7:0]);
                    state_d  = StWrReq;
                end
            end
            StRdReq: begin
                if (sdram.ack) begin
                    state_d = StRdWait;
                    req_d   = 1'b0;
                end else if (wdog_hit) begin
                    timeout_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = StDone;
                end
            end
            StRdWait: begin
                if (sdram.data_r_en) begin
                    if (sdram.data_r != exp_rd) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == '0) begin
                            fe_addr_d = addr_q;
                            fe_exp_d  = exp_rd;
                            fe_act_d  = sdram.data_r;
                        end
                    end
                    if (addr_q == LAST_ADDR) begin
                        pass_d = pass_q + 16'd1;
                        if (loop) begin
                            addr_d   = '0;
                            req_d    = 1'b1;
                            rh_wl_d  = 1'b0;
                            data_w_d = pat('0, pass_d[7:0]);
                            state_d  = StWrReq;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        req_d   = 1'b1;
                        rh_wl_d = 1'b1;
                        state_d = StRdReq;
                    end
                end else if (wdog_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q == StWrReq || state_q == StRdReq || state_q == StRdWait) begin
            wdog_d = wdog_q + WdW'(1);
        end else begin
            wdog_d = wdog_q;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            req_q     <= 1'b0;
            rh_wl_q   <= 1'b0;
            data_w_q  <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            pass_q    <= '0;
            err_q     <= '0;
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_act_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            rh_wl_q   <= rh_wl_d;
            data_w_q  <= data_w_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_act_q  <= fe_act_d;
        end
    end

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign done           = (state_q == StDone);
    assign timeout        = timeout_q;
    assign pass_cnt       = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_act  = fe_act_q;
    assign sdram.req      = req_q;
    assign sdram.addr     = addr_q;
    assign sdram.rh_wl    = rh_wl_q;
    assign sdram.data_w   = data_w_q;

endmodule

// File: tb/tb_sdram_tester.sv
// Bench for sdram_tester: an 8-word controller model acks requests and returns read data;
// every accepted transaction is checked against a queue of expected transactions.
module tb_sdram_tester;

    localparam int unsigned AW      = 22;
    localparam int unsigned LAST    = 7;
    localparam int unsigned TIMEOUT = 16383;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        busy, done, timeout;
    logic [15:0] pass_cnt, err_cnt, first_err_exp, first_err_act;
    logic [AW-1:0] first_err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic        ack_en = 1'b1;
    logic        corrupt = 1'b0;
    logic        stray_arm = 1'b0;
    logic        stray_fired = 1'b0;
    logic        rd_pending = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data = '0;
    logic [15:0] mem [0:7];
    logic [63:0] exp_q [$];

    sdram_tester_if #(.ADDR_WIDTH(AW)) sdram_bus ();

    sdram_tester #(
        .ADDR_WIDTH(AW),
        .LAST_ADDR (AW'(LAST)),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .start         (start),
        .loop          (loop),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .pass_cnt      (pass_cnt),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act),
        .sdram         (sdram_bus.master)
    );

    always #10 clk = ~clk;

    initial begin
        sdram_bus.ack       = 1'b0;
        sdram_bus.data_r    = '0;
        sdram_bus.data_r_en = 1'b0;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_txn(input logic rw, input logic [AW-1:0] a,
                                           input logic [15:0] d);
        return {25'd0, rw, a, d};
    endfunction

    // Small addresses only: the high address half is zero, so the pattern is a ^ {p,p}.
    task automatic push_pass(input logic [7:0] p);
        for (int a = 0; a <= int'(LAST); a++) exp_q.push_back(mk_txn(1'b0, AW'(a), 16'(a) ^ {p, p}));
        for (int a = 0; a <= int'(LAST); a++) exp_q.push_back(mk_txn(1'b1, AW'(a), 16'h0));
    endtask

    // Controller model, acting on the falling edge so the DUT sees stable inputs.
    always @(negedge clk) begin : model
        logic [63:0] txn;
        if (!reset_l) begin
            sdram_bus.ack       = 1'b0;
            sdram_bus.data_r_en = 1'b0;
            rd_pending          = 1'b0;
        end else begin
            sdram_bus.data_r_en = 1'b0;
            if (rd_pending) begin
                sdram_bus.data_r    = rd_data;
                sdram_bus.data_r_en = 1'b1;
                rd_pending          = 1'b0;
            end
            if (sdram_bus.ack) begin
                sdram_bus.ack = 1'b0;
            end else if (sdram_bus.req && ack_en) begin
                sdram_bus.ack = 1'b1;
                txn = mk_txn(sdram_bus.rh_wl, sdram_bus.addr,
                             sdram_bus.rh_wl ? 16'h0 : sdram_bus.data_w);
                if (exp_q.size() > 0) check_val("sb_txn", txn, exp_q.pop_front());
                else check_val("sb_unexpected_txn", txn, '1);
                if (sdram_bus.rh_wl) begin
                    rd_addr    = sdram_bus.addr[2:0];
                    rd_data    = mem[rd_addr] ^ ((corrupt && rd_addr == 3'd5) ? 16'h1 : 16'h0);
                    rd_pending = 1'b1;
                end else begin
                    mem[sdram_bus.addr[2:0]] = sdram_bus.data_w;
                end
            end
            if (stray_arm && !stray_fired && sdram_bus.req && !sdram_bus.rh_wl &&
                !sdram_bus.data_r_en) begin
                sdram_bus.data_r    = 16'hDEAD;
                sdram_bus.data_r_en = 1'b1;
                stray_fired         = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check_val({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_timeout"}, 64'(timeout), 64'd0);
        check_val({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        check_val({tag, "_err"}, 64'(err_cnt), 64'd0);
        check_val({tag, "_fe"}, {first_err_addr, first_err_exp, first_err_act}, 64'd0);
        check_val({tag, "_bus"}, {sdram_bus.req, sdram_bus.rh_wl, sdram_bus.addr,
                                  sdram_bus.data_w}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_l = 1'b1;

        // Single clean pass.
        push_pass(8'h00);
        pulse_start();
        check_val("start_busy", 64'(busy), 64'd1);
        check_val("start_req", {sdram_bus.req, sdram_bus.rh_wl, sdram_bus.addr}, {2'b10, AW'(0)});
        wait_done("p1");
        check_val("p1_pass", 64'(pass_cnt), 64'd1);
        check_val("p1_err", 64'(err_cnt), 64'd0);
        check_val("p1_timeout", 64'(timeout), 64'd0);
        check_val("p1_drained", 64'(exp_q.size()), 64'd0);

        // Corrupted read at address 5.
        corrupt = 1'b1;
        push_pass(8'h00);
        pulse_start();
        wait_done("cor");
        check_val("cor_err", 64'(err_cnt), 64'd1);
        check_val("cor_fe_addr", 64'(first_err_addr), 64'd5);
        check_val("cor_fe_exp", 64'(first_err_exp), 64'h0005);
        check_val("cor_fe_act", 64'(first_err_act), 64'h0004);
        check_val("cor_pass", 64'(pass_cnt), 64'd1);
        corrupt = 1'b0;

        // Looping: second pass uses p=1; loop is dropped once pass 2 is under way.
        loop = 1'b1;
        push_pass(8'h00);
        push_pass(8'h01);
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            if (pass_cnt == 16'd1) break;
            @(posedge clk);
            #1;
        end
        check_val("loop_p1", 64'(pass_cnt), 64'd1);
        check_val("loop_busy", 64'(busy), 64'd1);
        loop = 1'b0;
        wait_done("loop");
        check_val("loop_pass", 64'(pass_cnt), 64'd2);
        check_val("loop_drained", 64'(exp_q.size()), 64'd0);

        // Start while busy and a stray read-valid during a write are both ignored.
        push_pass(8'h00);
        pulse_start();
        stray_arm = 1'b1;
        repeat (4) @(posedge clk);
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        wait_done("stray");
        check_val("stray_fired", 64'(stray_fired), 64'd1);
        check_val("stray_err", 64'(err_cnt), 64'd0);
        check_val("stray_pass", 64'(pass_cnt), 64'd1);
        check_val("stray_drained", 64'(exp_q.size()), 64'd0);

        // Controller never acks: abort exactly TIMEOUT cycles after req rises.
        ack_en = 1'b0;
        pulse_start();
        check_val("to_req_rise", 64'(sdram_bus.req), 64'd1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check_val("to_before", {timeout, sdram_bus.req, done}, 64'b010);
        @(posedge clk);
        #1;
        check_val("to_after", {timeout, sdram_bus.req, done}, 64'b101);
        check_val("to_pass", 64'(pass_cnt), 64'd0);
        ack_en = 1'b1;

        // Reset while waiting for read data at address 6 (after the address-5 error).
        corrupt = 1'b1;
        push_pass(8'h00);
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (rd_pending && rd_addr == 3'd6) break;
        end
        check_val("rst_pre_err", 64'(err_cnt), 64'd1);
        reset_l = 1'b0;
        #1;
        check_all_zero("rst_mid");
        corrupt = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        push_pass(8'h00);
        pulse_start();
        wait_done("rerun");
        check_val("rerun_pass", 64'(pass_cnt), 64'd1);
        check_val("rerun_err", 64'(err_cnt), 64'd0);
        check_val("rerun_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_tester.md
# sdram_tester

Built-in memory test sequencer that drives the SDRAM controller's client port. It writes an address-derived pattern across a configurable address range, then reads every location back. It compares each read against the expected value, counts mismatches and captures the first failure. It sits directly upstream of the SDRAM controller in the sdramtest design and is its only client.

## Interface
- ADDR_WIDTH, 22, client address width (bank+row+col); legal range 17..32.
- LAST_ADDR, 22'h3FFFFF, highest address tested; range is 0..LAST_ADDR inclusive.
- TIMEOUT, 16383, cycles to wait for ack or read data before aborting; must exceed the controller power-on wait (10000).
- clk  in  1  system clock (50 MHz).
- reset_l  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a test from IDLE or DONE.
- loop  in  1  sampled at end of each pass; 1 = run another pass.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.
- timeout  out  1  sticky abort flag.
- pass_cnt  out  16  completed passes; wraps.
- err_cnt  out  16  mismatches; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- first_err_exp  out  16  expected data at the first mismatch.
- first_err_act  out  16  read data at the first mismatch.
- sdram_req  out  1  transaction request.
- sdram_ack  in  1  one-cycle acceptance pulse from the controller.
- sdram_addr  out  ADDR_WIDTH  {bank,row,col}.
- sdram_rh_wl  out  1  1 = read, 0 = write.
- sdram_data_w  out  16  write data.
- sdram_data_r  in  16  read data.
- sdram_data_r_en  in  1  one-cycle read-data-valid pulse.

## Operation
- Pattern: pat(a,p) = a[15:0] ^ (a >> 16)[15:0] ^ {p[7:0],p[7:0]}, where p = pass_cnt at the start of the pass.
- States:
  - IDLE: on start, clear all counters, flags and captures; addr=0; go to WR_REQ.
  - WR_REQ: req=1, rh_wl=0, sdram_data_w=pat(addr,p).
    - On ack: go to WR_GAP.
  - WR_GAP: req=0 for exactly one cycle.
    - If addr==LAST_ADDR: addr=0, go to RD_REQ.
    - Else: addr+1, go to WR_REQ.
  - RD_REQ: req=1, rh_wl=1.
    - On ack: req=0, go to RD_WAIT.
  - RD_WAIT: on data_r_en, compare sdram_data_r to pat(addr,p).
    - Mismatch: err_cnt+1 (saturating). If err_cnt was 0, capture addr, expected value and actual value.
    - Then, if addr==LAST_ADDR: pass_cnt+1. If loop=1: addr=0, go to WR_REQ with the new p. Else go to DONE.
    - Else: addr+1, go to RD_REQ.
  - DONE: req=0, results held. On start, behave as IDLE.
- Request outputs are registered. addr, rh_wl and data_w are stable from req rise through the cycle in which ack is high. They change only on the edge that samples ack.
- Ack in any state other than WR_REQ or RD_REQ is ignored.
- data_r_en outside RD_WAIT is ignored.
- start while busy is ignored.
- Watchdog counter:
  - Clears on every state entry.
  - Counts in WR_REQ, RD_REQ and RD_WAIT.
  - On reaching TIMEOUT: timeout=1, req=0, go to DONE.
- Address and pass_cnt arithmetic is modulo width.
- err_cnt never wraps.

## Timing
- Reset values:
  - All outputs are 0, including sdram_req, busy, done, timeout, all counters, all captures, sdram_addr, sdram_data_w and sdram_rh_wl.
  - State is IDLE.
  - Reset mid-transaction drops req asynchronously. No pending read is completed.
- busy rises on the cycle after start.
- req rises on the cycle after start.
- req falls on the cycle after ack is high.
- err_cnt and the first-error captures update on the cycle after data_r_en.
- The next read request rises on the cycle after data_r_en.
- done rises on the cycle after the last data_r_en of the final pass, together with the pass_cnt increment.
- Simultaneous ack and watchdog expiry: ack wins.

## Test plan
- LAST_ADDR=7, loop=0, ideal controller model -> writes 0..7 with data 0x0000..0x0007, then reads 0..7; pass_cnt=1, err_cnt=0, done=1, timeout=0.
- Model returns data^0x0001 at addr 5 -> err_cnt=1, first_err_addr=5, first_err_exp=0x0005, first_err_act=0x0004; the test still completes.
- loop=1, LAST_ADDR=3 -> pass 1 writes 0x0101,0x0100,0x0103,0x0102; drop loop during pass 2 -> done with pass_cnt=2.
- Model never acks -> at TIMEOUT cycles after req rises: timeout=1, req=0, done=1, pass_cnt=0.
- Assert reset_l low during RD_WAIT -> req=0 immediately and all outputs 0. A later start runs cleanly from addr 0.
- start pulses while busy plus a stray data_r_en in WR_REQ -> no restart and no err_cnt change.
